mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port memory.
// Data wins by default; a waiting fetch is forced through after MAX_D_STREAK data grants.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 m_req,
  output logic                 m_we,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ack,
  output logic                 busy,
  output logic [15:0]          conflict_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [1:0]           state;
  logic                 grant_d;
  logic                 lat_we;
  logic [WORD_SIZE-1:0] lat_addr;
  logic [WORD_SIZE-1:0] lat_wdata;
  logic [SW-1:0]        streak;
  logic                 d_win;

  always_comb begin
    d_win = d_req && (!i_req || (streak < STREAK_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant_d        <= 1'b0;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      streak         <= '0;
      conflict_count <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req && (conflict_count != '1))
            conflict_count <= conflict_count + 16'd1;
          if (d_win) begin
            lat_we    <= d_we;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            grant_d   <= 1'b1;
            state     <= D_BUSY;
            // Streak only counts data grants that actually made a fetch wait.
            if (!i_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 1'b1;
          end else if (i_req) begin
            lat_we    <= 1'b0;
            lat_addr  <= i_addr;
            lat_wdata <= '0;
            grant_d   <= 1'b0;
            state     <= I_BUSY;
            streak    <= '0;
          end
        end
        I_BUSY: begin
          if (m_ack) begin
            i_rdata <= m_rdata;
            state   <= DONE;
          end
        end
        D_BUSY: begin
          if (m_ack) begin
            if (!lat_we)
              d_rdata <= m_rdata;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    m_req   = (state == I_BUSY) || (state == D_BUSY);
    m_we    = (state == D_BUSY) && lat_we;
    m_addr  = lat_addr;
    m_wdata = lat_wdata;
    i_ready = (state == DONE) && !grant_d;
    d_ready = (state == DONE) && grant_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory responder plus
// per-scenario tasks with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;
  logic        busy;
  logic [15:0] conflict_count;

  logic        mem_en;
  int          ack_lat;
  logic [15:0] rd_val;
  logic        resp_ack   = 1'b0;
  logic [15:0] resp_rdata = 16'h0000;
  int          resp_cnt   = 0;
  logic        man_ack;
  logic [15:0] man_rdata;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WORD_SIZE(16), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  assign m_ack   = resp_ack | man_ack;
  assign m_rdata = man_ack ? man_rdata : resp_rdata;

  // Acks after ack_lat cycles of m_req being high; one-cycle pulse.
  always @(negedge clk) begin
    if (resp_ack) begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
    end else if (mem_en && m_req) begin
      resp_cnt <= resp_cnt + 1;
      if (resp_cnt + 1 >= ack_lat) begin
        resp_ack   <= 1'b1;
        resp_rdata <= rd_val;
      end
    end else begin
      resp_cnt <= 0;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, m_req, m_we, i_ready, d_ready} !== 5'b0)
      $display("FAIL reset_ctrl: got %b, expected 00000", {busy, m_req, m_we, i_ready, d_ready});
    tests++;
    if (conflict_count !== 16'h0000)
      $display("FAIL reset_conflict: got %h, expected 0000", conflict_count);
    tests++;
    if ({i_rdata, d_rdata} !== 32'h0)
      $display("FAIL reset_rdata: got %h/%h, expected 0000/0000", i_rdata, d_rdata);
    tests++;
    if ({m_addr, m_wdata} !== 32'h0)
      $display("FAIL reset_maddr: got %h/%h, expected 0000/0000", m_addr, m_wdata);
    if (({busy, m_req, m_we, i_ready, d_ready} !== 5'b0) || (conflict_count !== 16'h0000) ||
        ({i_rdata, d_rdata} !== 32'h0) || ({m_addr, m_wdata} !== 32'h0))
      fails++;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_i_read();
    int rdy_at = -1;
    int mreq_n = 0;
    int bad = 0;
    int d_seen = 0;
    logic [15:0] got = 16'h0;
    mem_en = 1'b1; ack_lat = 2; rd_val = 16'hA5A5;
    i_addr = 16'h0010; i_req = 1'b1;
    for (int c = 1; c <= 20 && rdy_at < 0; c++) begin
      @(negedge clk);
      if (m_req) begin
        mreq_n++;
        if (m_addr !== 16'h0010 || m_we !== 1'b0) bad++;
      end
      if (d_ready) d_seen++;
      if (i_ready) begin
        rdy_at = c;
        got = i_rdata;
        i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    tests++;
    if (rdy_at != 3) begin
      fails++;
      $display("FAIL i_read_latency: i_ready at cycle %0d, expected 3 (-1 = timeout)", rdy_at);
    end
    tests++;
    if (mreq_n != 2) begin
      fails++;
      $display("FAIL i_read_mreq_cycles: got %0d, expected 2", mreq_n);
    end
    tests++;
    if (bad != 0 || d_seen != 0) begin
      fails++;
      $display("FAIL i_read_bus: bad addr/we cycles %0d, d_ready pulses %0d, expected 0/0", bad, d_seen);
    end
    tests++;
    if (got !== 16'hA5A5) begin
      fails++;
      $display("FAIL i_read_data: got %h, expected a5a5", got);
    end
    @(negedge clk);
    tests++;
    if ({i_ready, busy} !== 2'b00) begin
      fails++;
      $display("FAIL i_read_after: i_ready/busy got %b, expected 00", {i_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_vals [3];
    int n = 0;
    exp_vals[0] = 16'h1111; exp_vals[1] = 16'h2222; exp_vals[2] = 16'h3333;
    ack_lat = 1; rd_val = exp_vals[0];
    d_we = 1'b0; d_addr = 16'h0040; d_req = 1'b1;
    for (int c = 1; c <= 30 && n < 3; c++) begin
      @(negedge clk);
      if (d_ready) begin
        tests++;
        if (c != 2 + 3 * n) begin
          fails++;
          $display("FAIL b2b_timing: d_ready #%0d at cycle %0d, expected %0d", n, c, 2 + 3 * n);
        end
        tests++;
        if (d_rdata !== exp_vals[n]) begin
          fails++;
          $display("FAIL b2b_data: read #%0d got %h, expected %h", n, d_rdata, exp_vals[n]);
        end
        n++;
        if (n < 3) rd_val = exp_vals[n];
        else d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d completions, expected 3", n);
    end
    @(negedge clk);
  endtask

  task automatic test_d_write();
    int rdy_at = -1;
    int mreq_n = 0;
    int bad = 0;
    logic [15:0] got = 16'h0;
    ack_lat = 3; rd_val = 16'hBEEF;
    d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; d_req = 1'b1;
    for (int c = 1; c <= 20 && rdy_at < 0; c++) begin
      @(negedge clk);
      if (m_req) begin
        mreq_n++;
        if (m_we !== 1'b1 || m_addr !== 16'h0200 || m_wdata !== 16'h1234) bad++;
        // Disturb the requester inputs; the access in flight must not move.
        d_addr = 16'hFFFF; d_wdata = 16'h0000; d_we = 1'b0;
      end
      if (d_ready) begin
        rdy_at = c;
        got = d_rdata;
        d_req = 1'b0;
      end
    end
    d_req = 1'b0; d_we = 1'b0;
    tests++;
    if (rdy_at != 4 || mreq_n != 3) begin
      fails++;
      $display("FAIL d_write_timing: ready at %0d with %0d m_req cycles, expected 4 and 3", rdy_at, mreq_n);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL d_write_bus: %0d cycles with wrong m_we/m_addr/m_wdata, expected 0", bad);
    end
    tests++;
    if (got !== 16'h3333) begin
      fails++;
      $display("FAIL d_write_rdata: got %h, expected 3333 (unchanged)", got);
    end
    @(negedge clk);
    tests++;
    if ({d_ready, busy} !== 2'b00) begin
      fails++;
      $display("FAIL d_write_after: d_ready/busy got %b, expected 00", {d_ready, busy});
    end
  endtask

  task automatic test_streak();
    string order = "DDDDIDDDDI";
    int n = 0;
    int both = 0;
    byte got;
    ack_lat = 1; rd_val = 16'h4321;
    d_we = 1'b0; d_addr = 16'h0080; i_addr = 16'h0090;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 80 && n < 10; c++) begin
      @(negedge clk);
      if (i_ready && d_ready) both++;
      if (i_ready || d_ready) begin
        got = d_ready ? "D" : "I";
        tests++;
        if (got != order[n]) begin
          fails++;
          $display("FAIL streak_order: grant #%0d got %c, expected %c", n, got, order[n]);
        end
        tests++;
        if (conflict_count !== 16'(n + 1)) begin
          fails++;
          $display("FAIL streak_conflict: after grant #%0d got %0d, expected %0d", n, conflict_count, n + 1);
        end
        n++;
        if (n == 10) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tests++;
    if (n != 10 || both != 0) begin
      fails++;
      $display("FAIL streak_count: %0d grants, %0d double-ready cycles, expected 10 and 0", n, both);
    end
    @(negedge clk);
    tests++;
    if (conflict_count !== 16'd10) begin
      fails++;
      $display("FAIL streak_conflict_final: got %0d, expected 10", conflict_count);
    end
  endtask

  task automatic test_spurious_ack();
    man_rdata = 16'hFFFF; man_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      man_ack = 1'b0;
      tests++;
      if ({busy, m_req, i_ready, d_ready} !== 4'b0000) begin
        fails++;
        $display("FAIL spurious_ctrl: cycle %0d got %b, expected 0000", c, {busy, m_req, i_ready, d_ready});
      end
      tests++;
      if (i_rdata !== 16'h4321 || d_rdata !== 16'h4321) begin
        fails++;
        $display("FAIL spurious_data: cycle %0d got %h/%h, expected 4321/4321", c, i_rdata, d_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int in_busy = 0;
    mem_en = 1'b0;
    d_we = 1'b0; d_addr = 16'h0300; d_req = 1'b1;
    for (int c = 0; c < 10 && in_busy == 0; c++) begin
      @(negedge clk);
      if (busy && m_req) in_busy = 1;
    end
    tests++;
    if (in_busy != 1) begin
      fails++;
      $display("FAIL rst_mid_reach: D_BUSY reached %0d, expected 1", in_busy);
    end
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({busy, m_req} !== 2'b00 || conflict_count !== 16'h0000 || m_addr !== 16'h0000) begin
      fails++;
      $display("FAIL rst_mid_state: busy/m_req %b conflict %h m_addr %h, expected 00/0000/0000",
               {busy, m_req}, conflict_count, m_addr);
    end
    man_rdata = 16'hABCD; man_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      man_ack = 1'b0;
      tests++;
      if ({busy, i_ready, d_ready} !== 3'b000 || d_rdata !== 16'h0000 || i_rdata !== 16'h0000) begin
        fails++;
        $display("FAIL rst_mid_late_ack: cycle %0d busy/rdy %b rdata %h/%h, expected 000 0000/0000",
                 c, {busy, i_ready, d_ready}, i_rdata, d_rdata);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    mem_en = 1'b0; ack_lat = 1; rd_val = 16'h0;
    man_ack = 1'b0; man_rdata = 16'h0;
    test_reset();
    test_i_read();
    test_back_to_back();
    test_d_write();
    test_streak();
    test_spurious_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
